// File: rtl/btb_set_assoc_if.sv
// Fetch-lookup / Execute-update bundle for the set-associative BTB.
interface btb_set_assoc_if #(
  parameter int XLEN = 32,
  parameter int PC_W = 20
);
  logic [PC_W-1:0] pc_F;
  logic            hit;
  logic [XLEN-1:0] pc_out;
  logic            pred_taken;
  logic            upd_valid;
  logic [PC_W-1:0] upd_pc;
  logic [XLEN-1:0] upd_target;
  logic            upd_taken;
  logic            upd_jump;
  logic            flush;

  modport master (output pc_F, upd_valid, upd_pc, upd_target, upd_taken, upd_jump, flush,
                  input  hit, pc_out, pred_taken);
  modport slave  (input  pc_F, upd_valid, upd_pc, upd_target, upd_taken, upd_jump, flush,
                  output hit, pc_out, pred_taken);
endinterface

// File: rtl/btb_set_assoc.sv
// Set-associative BTB with 2-bit direction counters, round-robin replacement and flush.
// Optional performance counters are built in when BTB_PERF_EN is defined.
module btb_set_assoc #(
  parameter int XLEN = 32,
  parameter int PC_W = 20,
  parameter int SETS = 256,
  parameter int WAYS = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  btb_set_assoc_if.slave bif
`ifdef BTB_PERF_EN
  ,
  output logic [31:0] perf_lookups,
  output logic [31:0] perf_hits,
  output logic [31:0] perf_allocs
`endif
);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = PC_W - IDX_W;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  logic [WAYS-1:0]  valid_q [SETS];
  logic [TAG_W-1:0] tag_q   [SETS][WAYS];
  logic [XLEN-1:0]  tgt_q   [SETS][WAYS];
  logic [1:0]       ctr_q   [SETS][WAYS];
  logic [WAY_W-1:0] rr_q    [SETS];

  logic [IDX_W-1:0] idx_f, idx_u;
  logic [TAG_W-1:0] tag_f, tag_u;
  logic             hit_f, hit_u, inv_found, alloc_en;
  logic [WAY_W-1:0] way_f, way_u, inv_way, victim;
  logic [1:0]       ctr_d;

  assign idx_f = bif.pc_F[IDX_W-1:0];
  assign tag_f = bif.pc_F[PC_W-1:IDX_W];
  assign idx_u = bif.upd_pc[IDX_W-1:0];
  assign tag_u = bif.upd_pc[PC_W-1:IDX_W];

  // Scan high-to-low so the lowest matching / invalid way ends up selected.
  always_comb begin
    hit_f     = 1'b0;
    way_f     = '0;
    hit_u     = 1'b0;
    way_u     = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[idx_f][w] && tag_q[idx_f][w] == tag_f) begin
        hit_f = 1'b1;
        way_f = WAY_W'(w);
      end
      if (valid_q[idx_u][w] && tag_q[idx_u][w] == tag_u) begin
        hit_u = 1'b1;
        way_u = WAY_W'(w);
      end
      if (!valid_q[idx_u][w]) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
    end
  end

  assign bif.hit        = hit_f;
  assign bif.pc_out     = hit_f ? tgt_q[idx_f][way_f] : '0;
  assign bif.pred_taken = hit_f & ctr_q[idx_f][way_f][1];

  assign victim   = inv_found ? inv_way : ((WAYS > 1) ? rr_q[idx_u] : '0);
  assign alloc_en = bif.upd_valid & ~bif.flush & ~hit_u & (bif.upd_jump | bif.upd_taken);

  always_comb begin
    ctr_d = ctr_q[idx_u][way_u];
    if (bif.upd_jump)
      ctr_d = 2'b11;
    else if (bif.upd_taken) begin
      if (ctr_d != 2'b11) ctr_d = ctr_d + 2'd1;
    end else begin
      if (ctr_d != 2'b00) ctr_d = ctr_d - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        rr_q[s]    <= '0;
        for (int w = 0; w < WAYS; w++) ctr_q[s][w] <= 2'b01;
      end
    end else if (bif.flush) begin
      for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
    end else if (bif.upd_valid) begin
      if (hit_u) begin
        tgt_q[idx_u][way_u] <= bif.upd_target;
        ctr_q[idx_u][way_u] <= ctr_d;
      end else if (alloc_en) begin
        valid_q[idx_u][victim] <= 1'b1;
        tag_q[idx_u][victim]   <= tag_u;
        tgt_q[idx_u][victim]   <= bif.upd_target;
        ctr_q[idx_u][victim]   <= bif.upd_jump ? 2'b11 : 2'b10;
        // rr only moves when a full set forces an eviction
        if (!inv_found && WAYS > 1) rr_q[idx_u] <= rr_q[idx_u] + 1'b1;
      end
    end
  end

`ifdef BTB_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_lookups <= '0;
      perf_hits    <= '0;
      perf_allocs  <= '0;
    end else begin
      perf_lookups <= perf_lookups + 32'd1;
      perf_hits    <= perf_hits + {31'd0, hit_f};
      perf_allocs  <= perf_allocs + {31'd0, alloc_en};
    end
  end
`endif
endmodule

// File: tb/tb_btb_set_assoc.sv
// Randomised scoreboard bench for btb_set_assoc against a per-set behavioural model.
module tb_btb_set_assoc;
  localparam int XLEN = 32, PC_W = 20, SETS = 256, WAYS = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  btb_set_assoc_if #(.XLEN(XLEN), .PC_W(PC_W)) bif();
`ifdef BTB_PERF_EN
  logic [31:0] perf_lookups, perf_hits, perf_allocs;
`endif

  btb_set_assoc #(.XLEN(XLEN), .PC_W(PC_W), .SETS(SETS), .WAYS(WAYS)) dut (
    .clk(clk), .rst_n(rst_n), .bif(bif)
`ifdef BTB_PERF_EN
    , .perf_lookups(perf_lookups), .perf_hits(perf_hits), .perf_allocs(perf_allocs)
`endif
  );

  typedef struct {
    bit          hit;
    logic [31:0] pc;
    bit          pred;
    int unsigned lk, ht, al;
    string       nm;
  } exp_t;
  exp_t sb[$];

  int n_cmp = 0, n_bad = 0;

  // Behavioural model: each set is a small table of entries plus a replacement pointer.
  bit          m_v   [SETS][WAYS];
  int unsigned m_tag [SETS][WAYS];
  int unsigned m_tgt [SETS][WAYS];
  int          m_ctr [SETS][WAYS];
  int          m_rr  [SETS];
  int unsigned m_lk, m_ht, m_al;
  bit          m_init = 0;

  function automatic int m_find(int unsigned pc);
    int unsigned s = pc % SETS, t = pc / SETS;
    for (int w = 0; w < WAYS; w++)
      if (m_v[s][w] && m_tag[s][w] == t) return w;
    return -1;
  endfunction

  task automatic m_reset();
    for (int s = 0; s < SETS; s++) begin
      m_rr[s] = 0;
      for (int w = 0; w < WAYS; w++) begin m_v[s][w] = 0; m_ctr[s][w] = 1; end
    end
    m_lk = 0; m_ht = 0; m_al = 0; m_init = 1;
  endtask

  task automatic m_update(int unsigned pc, int unsigned tgt, bit tk, bit jp);
    int unsigned s = pc % SETS;
    int w = m_find(pc);
    if (w >= 0) begin
      m_tgt[s][w] = tgt;
      if (jp) m_ctr[s][w] = 3;
      else if (tk) m_ctr[s][w] = (m_ctr[s][w] < 3) ? m_ctr[s][w] + 1 : 3;
      else m_ctr[s][w] = (m_ctr[s][w] > 0) ? m_ctr[s][w] - 1 : 0;
    end else if (jp || tk) begin
      int v = -1;
      for (int k = 0; k < WAYS; k++) if (v < 0 && !m_v[s][k]) v = k;
      if (v < 0) begin v = m_rr[s]; m_rr[s] = (m_rr[s] + 1) % WAYS; end
      m_v[s][v] = 1; m_tag[s][v] = pc / SETS; m_tgt[s][v] = tgt;
      m_ctr[s][v] = jp ? 3 : 2;
      m_al++;
    end
  endtask

  // One clock of stimulus: drive, predict this cycle's lookup, then advance the model at the edge.
  task automatic step(bit rst, bit fl, bit uv, logic [19:0] upc, logic [31:0] ut,
                      bit tk, bit jp, logic [19:0] pcf, string nm);
    exp_t e;
    int w;
    rst_n = ~rst; bif.flush = fl; bif.upd_valid = uv; bif.upd_pc = upc;
    bif.upd_target = ut; bif.upd_taken = tk; bif.upd_jump = jp; bif.pc_F = pcf;
    w = m_find(pcf);
    e.hit  = m_init && (w >= 0);
    e.pc   = e.hit ? m_tgt[pcf % SETS][w] : 32'd0;
    e.pred = e.hit && (m_ctr[pcf % SETS][w] >= 2);
    e.lk = m_lk; e.ht = m_ht; e.al = m_al; e.nm = nm;
    if (m_init) sb.push_back(e);
    @(posedge clk);
    if (rst) m_reset();
    else if (m_init) begin
      m_lk++;
      if (e.hit) m_ht++;
      if (fl) begin
        for (int s = 0; s < SETS; s++) for (int k = 0; k < WAYS; k++) m_v[s][k] = 0;
      end else if (uv) m_update(upc, ut, tk, jp);
    end
    #1;
  endtask

  task automatic look(logic [19:0] pcf, string nm);
    step(0, 0, 0, 20'h0, 32'h0, 0, 0, pcf, nm);
  endtask

  task automatic upd(logic [19:0] upc, logic [31:0] ut, bit tk, bit jp, logic [19:0] pcf, string nm);
    step(0, 0, 1, upc, ut, tk, jp, pcf, nm);
  endtask

  task automatic chk(string nm, string fld, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s.%s: got %h expected %h at %0t", nm, fld, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk(e.nm, "hit", {31'd0, bif.hit}, {31'd0, e.hit});
      chk(e.nm, "pc_out", bif.pc_out, e.pc);
      chk(e.nm, "pred_taken", {31'd0, bif.pred_taken}, {31'd0, e.pred});
`ifdef BTB_PERF_EN
      chk(e.nm, "perf_lookups", perf_lookups, e.lk);
      chk(e.nm, "perf_hits", perf_hits, e.ht);
      chk(e.nm, "perf_allocs", perf_allocs, e.al);
`endif
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [19:0] p, q;
    step(1, 0, 0, 0, 0, 0, 0, 20'h00010, "rst");
    step(1, 0, 0, 0, 0, 0, 0, 20'h00010, "rst");
    look(20'h00010, "t1_reset_miss");
    upd(20'h00010, 32'h80, 0, 1, 20'h00010, "t2_jump_upd");
    look(20'h00010, "t2_jump_hit");
    upd(20'h00020, 32'h440, 1, 0, 20'h00020, "t3_alloc");
    look(20'h00020, "t3_ctr2");
    upd(20'h00020, 32'h440, 0, 0, 20'h00020, "t3_nt1");
    look(20'h00020, "t3_ctr1");
    upd(20'h00020, 32'h440, 0, 0, 20'h00020, "t3_nt2");
    upd(20'h00020, 32'h444, 0, 0, 20'h00020, "t3_nt3_sat");
    upd(20'h00020, 32'h448, 1, 0, 20'h00020, "t3_tk1");
    upd(20'h00020, 32'h44c, 1, 0, 20'h00020, "t3_tk2");
    look(20'h00020, "t3_ctr2_again");
    upd(20'h00005, 32'h1000, 0, 1, 20'h00005, "t4_a0");
    upd(20'h00105, 32'h2000, 1, 0, 20'h00005, "t4_a1");
    upd(20'h00205, 32'h3000, 0, 1, 20'h00105, "t4_a2_evict");
    look(20'h00005, "t4_evicted");
    look(20'h00105, "t4_keep1");
    look(20'h00205, "t4_keep2");
    upd(20'h00305, 32'h4000, 0, 1, 20'h00205, "t4_rr1");
    look(20'h00105, "t4_rr_evict");
    look(20'h00205, "t4_rr_keep");
    upd(20'h00405, 32'h5000, 0, 0, 20'h00405, "t4_nt_no_alloc");
    look(20'h00405, "t4_nt_miss");
    step(0, 1, 1, 20'h00030, 32'h99, 0, 1, 20'h00030, "t5_flush");
    look(20'h00010, "t5_miss_a");
    look(20'h00030, "t5_miss_upd");
    look(20'h00305, "t5_miss_b");
    upd(20'h00044, 32'habc, 0, 1, 20'h00044, "t6_same_cycle");
    look(20'h00044, "t6_next");
    step(1, 0, 1, 20'h00055, 32'h55, 0, 1, 20'h00044, "t7_rst_pending");
    look(20'h00055, "t7_no_write");
    look(20'h00044, "t7_cleared");
    for (int i = 0; i < 3000; i++) begin
      p = {10'd0, 2'($urandom_range(0, 3)), 8'($urandom_range(5, 7))};
      q = {10'd0, 2'($urandom_range(0, 3)), 8'($urandom_range(5, 7))};
      step($urandom_range(0, 499) == 0, $urandom_range(0, 63) == 0, $urandom_range(0, 1) == 1,
           p, $urandom, $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0, q, "rand");
    end
    @(negedge clk);
    #1;
    chk("end", "sb_drain", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
